// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order retirement buffer for an out-of-order core.
//                Dispatch allocates up to DISPATCH_WIDTH consecutive entries
//                per cycle at the tail. Execute units mark entries done and
//                deliver results on NUM_CPL completion ports. The longest
//                done prefix starting at the head, up to RETIRE_WIDTH entries,
//                is presented on the register-file write ports every cycle.
//                Consumers cannot stall these writes.
//
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-low reset
//                disp_valid - per-lane allocate request, contiguous from lane 0
//                disp_areg  - destination architectural register per lane
//                disp_ready - room for a full DISPATCH_WIDTH group
//                disp_tag   - tag assigned to each dispatch lane
//                cpl_valid  - per-port completion strobe
//                cpl_tag    - per-port completing tag
//                cpl_data   - per-port result value
//                ret_valid  - per-lane retire strobe, in-order prefix
//                ret_areg   - per-lane retiring architectural register
//                ret_data   - per-lane retiring result
//                flush      - synchronous discard of every entry
//                empty      - no entries in flight
//                full       - every entry in flight
//                count      - number of entries in flight
//
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter  int NUM_ENTRIES    = 64,
    parameter  int DISPATCH_WIDTH = 2,
    parameter  int RETIRE_WIDTH   = 2,
    parameter  int NUM_CPL        = 2,
    parameter  int DATA_W         = 32,
    localparam int TAG_W          = $clog2(NUM_ENTRIES),
    localparam int AREG_W         = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
    input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_areg,
    output logic                             disp_ready,
    output logic [DISPATCH_WIDTH*TAG_W-1:0]  disp_tag,
    input  logic [NUM_CPL-1:0]               cpl_valid,
    input  logic [NUM_CPL*TAG_W-1:0]         cpl_tag,
    input  logic [NUM_CPL*DATA_W-1:0]        cpl_data,
    output logic [RETIRE_WIDTH-1:0]          ret_valid,
    output logic [RETIRE_WIDTH*AREG_W-1:0]   ret_areg,
    output logic [RETIRE_WIDTH*DATA_W-1:0]   ret_data,
    input  logic                             flush,
    output logic                             empty,
    output logic                             full,
    output logic [TAG_W:0]                   count
);

    localparam logic [TAG_W:0] c_entries    = (TAG_W+1)'(NUM_ENTRIES);
    localparam logic [TAG_W:0] c_disp_width = (TAG_W+1)'(DISPATCH_WIDTH);

    // ------------------------------------------------------------------
    // State. Pointers carry one wrap bit above the index so that the
    // occupancy is simply tail - head, with full and empty distinguished.
    // ------------------------------------------------------------------
    logic [TAG_W:0]            r_head;
    logic [TAG_W:0]            r_tail;
    logic [NUM_ENTRIES-1:0]    r_valid;
    logic [NUM_ENTRIES-1:0]    r_done;
    logic [AREG_W-1:0]         r_areg [NUM_ENTRIES];
    logic [DATA_W-1:0]         r_data [NUM_ENTRIES];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [TAG_W:0]            w_count;
    logic [TAG_W:0]            w_free;
    logic                      w_disp_fire;
    logic [TAG_W-1:0]          w_disp_idx [DISPATCH_WIDTH];
    logic [TAG_W-1:0]          w_ret_idx  [RETIRE_WIDTH];
    logic [RETIRE_WIDTH-1:0]   w_ret_ok;
    logic [RETIRE_WIDTH-1:0]   w_ret_valid;
    logic [TAG_W:0]            w_n_disp;
    logic [TAG_W:0]            w_n_ret;

    logic [NUM_ENTRIES-1:0]    w_alloc;
    logic [AREG_W-1:0]         w_alloc_areg [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    w_cpl_we;
    logic [DATA_W-1:0]         w_cpl_data   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]    w_retire;

    // ------------------------------------------------------------------
    // Occupancy and dispatch admission. Readiness uses only the registered
    // occupancy; entries retiring this cycle are not credited.
    // ------------------------------------------------------------------
    assign w_count     = r_tail - r_head;
    assign w_free      = c_entries - w_count;
    assign disp_ready  = (w_free >= c_disp_width);
    assign w_disp_fire = disp_ready && !flush && (|disp_valid);

    assign count = w_count;
    assign full  = (w_count == c_entries);
    assign empty = (w_count == '0);

    // Tag for each dispatch lane: consecutive slots from the tail, wrapping
    // naturally through the TAG_W-bit truncation.
    generate
        for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_disp_lane
            assign w_disp_idx[g]                = r_tail[TAG_W-1:0] + TAG_W'(g);
            assign disp_tag[g*TAG_W +: TAG_W]   = w_disp_idx[g];
        end
    endgenerate

    // Retire lanes look at consecutive slots from the head.
    generate
        for (genvar g = 0; g < RETIRE_WIDTH; g++) begin : g_ret_lane
            assign w_ret_idx[g]                   = r_head[TAG_W-1:0] + TAG_W'(g);
            assign w_ret_ok[g]                    = r_valid[w_ret_idx[g]] & r_done[w_ret_idx[g]];
            assign ret_areg[g*AREG_W +: AREG_W]   = r_areg[w_ret_idx[g]];
            assign ret_data[g*DATA_W +: DATA_W]   = r_data[w_ret_idx[g]];
        end
    endgenerate

    // A lane may retire only if every older lane also retires, so the
    // first entry that is not ready blocks everything behind it.
    always_comb begin
        logic run;
        run         = 1'b1;
        w_ret_valid = '0;
        for (int r = 0; r < RETIRE_WIDTH; r++) begin
            run            = run & w_ret_ok[r];
            w_ret_valid[r] = run;
        end
    end

    assign ret_valid = w_ret_valid;

    // Pointer advance amounts.
    always_comb begin
        w_n_disp = '0;
        w_n_ret  = '0;
        if (w_disp_fire) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                w_n_disp = w_n_disp + (TAG_W+1)'(disp_valid[l]);
            end
        end
        for (int r = 0; r < RETIRE_WIDTH; r++) begin
            w_n_ret = w_n_ret + (TAG_W+1)'(w_ret_valid[r]);
        end
    end

    // ------------------------------------------------------------------
    // Per-entry update strobes. Completion ports are scanned from the
    // highest number down so the lowest-numbered port overwrites and wins
    // when two ports name the same tag. A completion only lands on an entry
    // that was already allocated before this edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_alloc  = '0;
        w_cpl_we = '0;
        w_retire = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            w_alloc_areg[e] = '0;
            w_cpl_data[e]   = '0;
        end

        if (w_disp_fire) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (disp_valid[l]) begin
                    w_alloc[w_disp_idx[l]]      = 1'b1;
                    w_alloc_areg[w_disp_idx[l]] = disp_areg[l*AREG_W +: AREG_W];
                end
            end
        end

        if (!flush) begin
            for (int p = NUM_CPL-1; p >= 0; p--) begin
                if (cpl_valid[p] && r_valid[cpl_tag[p*TAG_W +: TAG_W]]) begin
                    w_cpl_we[cpl_tag[p*TAG_W +: TAG_W]]   = 1'b1;
                    w_cpl_data[cpl_tag[p*TAG_W +: TAG_W]] = cpl_data[p*DATA_W +: DATA_W];
                end
            end
        end

        for (int r = 0; r < RETIRE_WIDTH; r++) begin
            if (w_ret_valid[r]) begin
                w_retire[w_ret_idx[r]] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state. Allocation only targets free slots and retirement only
    // clears occupied ones, so the two never collide on one entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_head  <= r_head + w_n_ret;
            r_tail  <= r_tail + w_n_disp;
            r_valid <= (r_valid & ~w_retire) | w_alloc;
            r_done  <= (r_done | w_cpl_we) & ~w_retire & ~w_alloc;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (w_alloc[e]) begin
                r_areg[e] <= w_alloc_areg[e];
            end
            if (w_cpl_we[e]) begin
                r_data[e] <= w_cpl_data[e];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer. Dispatched entries
//                are queued in program order with their destination register;
//                the data each tag should carry is recorded when it is driven
//                on a completion port. Retire lanes are popped and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int NE     = 64;
    localparam int DW     = 2;
    localparam int TAG_W  = 6;
    localparam int AREG_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  disp_valid = '0;
    logic [9:0]  disp_areg  = '0;
    logic        disp_ready;
    logic [11:0] disp_tag;
    logic [1:0]  cpl_valid  = '0;
    logic [11:0] cpl_tag    = '0;
    logic [63:0] cpl_data   = '0;
    logic [1:0]  ret_valid;
    logic [9:0]  ret_areg;
    logic [63:0] ret_data;
    logic        flush = 1'b0;
    logic        empty;
    logic        full;
    logic [6:0]  count;

    reorder_buffer #(
        .NUM_ENTRIES    (64),
        .DISPATCH_WIDTH (2),
        .RETIRE_WIDTH   (2),
        .NUM_CPL        (2),
        .DATA_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_valid (disp_valid),
        .disp_areg  (disp_areg),
        .disp_ready (disp_ready),
        .disp_tag   (disp_tag),
        .cpl_valid  (cpl_valid),
        .cpl_tag    (cpl_tag),
        .cpl_data   (cpl_data),
        .ret_valid  (ret_valid),
        .ret_areg   (ret_areg),
        .ret_data   (ret_data),
        .flush      (flush),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [AREG_W-1:0] areg;
    } sb_t;

    sb_t              sb_q[$];
    logic [TAG_W-1:0] pend_q[$];
    logic [31:0]      exp_data [NE];
    logic [TAG_W-1:0] m_tail = '0;
    sb_t              mon_e;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Retire monitor: sampled mid-cycle, ignoring flush cycles and reset.
    always @(negedge clk) begin
        if (rst && !flush) begin
            if (ret_valid == 2'b10) check_eq("ret_prefix", ret_valid, 2'b11);
            for (int i = 0; i < 2; i++) begin
                if (ret_valid[i]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("ret_unexpected", ret_valid, 2'b00);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check_eq("ret_areg", ret_areg[i*AREG_W +: AREG_W], mon_e.areg);
                        check_eq("ret_data", ret_data[i*32 +: 32], exp_data[mon_e.tag]);
                    end
                end
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic run_cycle(input logic [1:0] dv, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [1:0] cv, input logic [5:0] t0, input logic [5:0] t1,
                             input logic [31:0] d0, input logic [31:0] d1, input logic fl);
        logic             exp_ready;
        logic [TAG_W-1:0] tag1;
        disp_valid = dv;
        disp_areg  = {a1, a0};
        cpl_valid  = cv;
        cpl_tag    = {t1, t0};
        cpl_data   = {d1, d0};
        flush      = fl;
        #1;
        exp_ready = (sb_q.size() <= NE - DW);
        tag1      = m_tail + 6'd1;
        check_eq("disp_ready", disp_ready, exp_ready);
        check_eq("disp_tag0", disp_tag[5:0], m_tail);
        check_eq("disp_tag1", disp_tag[11:6], tag1);
        check_eq("count", count, sb_q.size());
        check_eq("empty", empty, sb_q.size() == 0);
        check_eq("full", full, sb_q.size() == NE);
        if (!fl) begin
            if (cv[1]) exp_data[t1] = d1;
            if (cv[0]) exp_data[t0] = d0;
        end
        @(posedge clk);
        #1;
        disp_valid = '0;
        cpl_valid  = '0;
        flush      = 1'b0;
        if (fl) begin
            sb_q.delete();
            pend_q.delete();
            m_tail = '0;
        end else if (exp_ready) begin
            for (int i = 0; i < 2; i++) begin
                if (dv[i]) begin
                    sb_q.push_back('{tag: m_tail, areg: (i == 0) ? a0 : a1});
                    pend_q.push_back(m_tail);
                    m_tail = m_tail + 6'd1;
                end
            end
        end
    endtask

    task automatic pick(input int maxn, output logic [1:0] cv, output logic [5:0] t0, output logic [5:0] t1);
        int idx;
        cv = '0;
        t0 = '0;
        t1 = '0;
        if (maxn >= 1 && pend_q.size() > 0) begin
            idx = $urandom_range(0, pend_q.size() - 1);
            t0  = pend_q[idx];
            pend_q.delete(idx);
            cv[0] = 1'b1;
        end
        if (maxn >= 2 && pend_q.size() > 0) begin
            idx = $urandom_range(0, pend_q.size() - 1);
            t1  = pend_q[idx];
            pend_q.delete(idx);
            cv[1] = 1'b1;
        end
    endtask

    task automatic drop(input logic [5:0] tag);
        for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i] == tag) begin
                pend_q.delete(i);
                break;
            end
        end
    endtask

    task automatic rand_cycle();
        logic [1:0] dv, cv;
        logic [5:0] t0, t1;
        int         r;
        r  = $urandom_range(0, 2);
        dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
        pick($urandom_range(0, 2), cv, t0, t1);
        run_cycle(dv, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  cv, t0, t1, $urandom(), $urandom(), 1'b0);
    endtask

    task automatic drain(input string name);
        logic [1:0] cv;
        logic [5:0] t0, t1;
        for (int k = 0; k < 100 && sb_q.size() > 0; k++) begin
            pick(2, cv, t0, t1);
            run_cycle(2'b00, 5'd0, 5'd0, cv, t0, t1, $urandom(), $urandom(), 1'b0);
        end
        check_eq(name, count, 7'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held low.
        #12;
        check_eq("rst_ret_valid", ret_valid, 2'b00);
        check_eq("rst_full", full, 1'b0);
        check_eq("rst_empty", empty, 1'b1);
        check_eq("rst_ready", disp_ready, 1'b1);
        check_eq("rst_tag", disp_tag, {6'd1, 6'd0});
        check_eq("rst_count", count, 7'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Out-of-order completion, in-order two-wide retire.
        run_cycle(2'b11, 5'd3, 5'd4, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b01, 6'd1, 6'd0, 32'h11, 0, 1'b0);
        drop(6'd1);
        check_eq("ooo_no_ret", ret_valid, 2'b00);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b01, 6'd0, 6'd0, 32'h10, 0, 1'b0);
        drop(6'd0);
        check_eq("ooo_ret", ret_valid, 2'b11);
        check_eq("ooo_areg", ret_areg, {5'd4, 5'd3});
        run_cycle(2'b00, 5'd0, 5'd0, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);

        // Both completion ports carry tag 5: port 0 wins.
        run_cycle(2'b11, 5'd1, 5'd2, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        run_cycle(2'b11, 5'd5, 5'd6, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b11, 6'd5, 6'd5, 32'hA, 32'hB, 1'b0);
        drop(6'd5);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b11, 6'd2, 6'd3, 32'h22, 32'h33, 1'b0);
        drop(6'd2);
        drop(6'd3);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b01, 6'd4, 6'd0, 32'h44, 0, 1'b0);
        drop(6'd4);
        check_eq("dup_ret_valid", ret_valid, 2'b11);
        check_eq("dup_port0_wins", ret_data[63:32], 32'hA);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);

        // Completion on an unallocated tag is dropped.
        run_cycle(2'b00, 5'd0, 5'd0, 2'b01, 6'd6, 6'd0, 32'h55, 0, 1'b0);
        run_cycle(2'b01, 5'd9, 5'd0, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        check_eq("inval_cpl_ignored", ret_valid, 2'b00);

        // Mixed random traffic: simultaneous dispatch/complete/retire.
        for (int k = 0; k < 150; k++) rand_cycle();
        drain("drain_rand");

        // Fill to capacity; an extra dispatch is refused.
        for (int k = 0; k < 32; k++) begin
            run_cycle(2'b11, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        end
        check_eq("fill_full", full, 1'b1);
        check_eq("fill_ready", disp_ready, 1'b0);
        check_eq("fill_count", count, 7'd64);
        run_cycle(2'b11, 5'd30, 5'd31, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        check_eq("fill_tail_same", disp_tag[5:0], m_tail);
        check_eq("fill_count_same", count, 7'd64);
        drain("drain_fill");

        // Walk the tail to 62 and retire across the wrap.
        for (int k = 0; k < 64 && m_tail != 6'd62; k++) begin
            logic [1:0] cv;
            logic [5:0] t0, t1;
            pick(1, cv, t0, t1);
            run_cycle(2'b01, 5'd1, 5'd0, cv, t0, t1, $urandom(), 0, 1'b0);
        end
        drain("drain_walk");
        check_eq("wrap_tail62", disp_tag[5:0], 6'd62);
        run_cycle(2'b11, 5'd7, 5'd8, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        run_cycle(2'b00, 5'd0, 5'd0, 2'b11, 6'd62, 6'd63, 32'h62, 32'h63, 1'b0);
        drop(6'd62);
        drop(6'd63);
        check_eq("wrap_ret", ret_valid, 2'b11);
        check_eq("wrap_areg", ret_areg, {5'd8, 5'd7});
        run_cycle(2'b00, 5'd0, 5'd0, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        check_eq("wrap_tags", disp_tag, {6'd1, 6'd0});
        run_cycle(2'b11, 5'd10, 5'd11, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        drain("drain_wrap");

        // Flush beats dispatch and completion in the same cycle.
        for (int k = 0; k < 5; k++) begin
            run_cycle(2'b11, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        end
        check_eq("pre_flush_count", count, 7'd10);
        begin
            logic [1:0] cv;
            logic [5:0] t0, t1;
            pick(2, cv, t0, t1);
            run_cycle(2'b11, 5'd1, 5'd2, cv, t0, t1, 32'h1, 32'h2, 1'b1);
        end
        check_eq("flush_count", count, 7'd0);
        check_eq("flush_empty", empty, 1'b1);
        check_eq("flush_tag0", disp_tag[5:0], 6'd0);
        check_eq("flush_ret", ret_valid, 2'b00);

        // Asynchronous reset mid-cycle with six entries in flight.
        for (int k = 0; k < 3; k++) begin
            run_cycle(2'b11, 5'd12, 5'd13, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        end
        run_cycle(2'b00, 5'd0, 5'd0, 2'b11, 6'd0, 6'd1, 32'h70, 32'h71, 1'b0);
        drop(6'd0);
        drop(6'd1);
        check_eq("arst_pre_ret", ret_valid, 2'b11);
        check_eq("arst_pre_count", count, 7'd6);
        #1 rst = 1'b0;
        #1;
        check_eq("arst_ret_valid", ret_valid, 2'b00);
        check_eq("arst_count", count, 7'd0);
        check_eq("arst_empty", empty, 1'b1);
        check_eq("arst_full", full, 1'b0);
        check_eq("arst_ready", disp_ready, 1'b1);
        check_eq("arst_tag", disp_tag, {6'd1, 6'd0});
        sb_q.delete();
        pend_q.delete();
        m_tail = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_post_ret", ret_valid, 2'b00);
        run_cycle(2'b11, 5'd20, 5'd21, 2'b00, 6'd0, 6'd0, 0, 0, 1'b0);
        drain("drain_final");
        check_eq("final_empty", empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, total entries (power of 2, at least 4).
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 2, allocations per cycle.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 2, retirements per cycle (at most NUM_ENTRIES).
REQ-004 SHALL have parameter NUM_CPL, default 2, completion ports.
REQ-005 SHALL have parameter DATA_W, default 32, result width. TAG_W = log2(NUM_ENTRIES). AREG_W = 5.
REQ-006 SHALL have port clk, in, 1, single clock, rising edge.
REQ-007 SHALL have port rst, in, 1, asynchronous active-low reset.
REQ-008 SHALL have port disp_valid, in, DISPATCH_WIDTH, per-lane allocate request.
REQ-009 SHALL have port disp_areg, in, DISPATCH_WIDTH*AREG_W, destination architectural register per lane.
REQ-010 SHALL have port disp_ready, out, 1, space for DISPATCH_WIDTH entries.
REQ-011 SHALL have port disp_tag, out, DISPATCH_WIDTH*TAG_W, tag assigned to each lane.
REQ-012 SHALL have ports cpl_valid (in, NUM_CPL), cpl_tag (in, NUM_CPL*TAG_W) and cpl_data (in, NUM_CPL*DATA_W), the execute completion ports.
REQ-013 SHALL have ports ret_valid (out, RETIRE_WIDTH), ret_areg (out, RETIRE_WIDTH*AREG_W) and ret_data (out, RETIRE_WIDTH*DATA_W), the register-file write ports.
REQ-014 SHALL have port flush, in, 1, synchronous discard of all entries.
REQ-015 SHALL have ports empty (out, 1), full (out, 1) and count (out, TAG_W+1).

Function
REQ-016 SHALL be a circular buffer with head and tail pointers of TAG_W+1 bits. The extra bit is the wrap bit. Index = pointer mod NUM_ENTRIES.
REQ-017 Each entry SHALL hold: valid, done, areg, data.
REQ-018 disp_ready SHALL be 1 iff (NUM_ENTRIES - count) >= DISPATCH_WIDTH, computed from registered count only (same-cycle retires not credited).
REQ-019 disp_valid lanes SHALL be contiguous from lane 0; a dispatch is accepted only when disp_ready=1; lanes with disp_valid=1 and disp_ready=0 are ignored.
REQ-020 disp_tag lane i SHALL equal (tail+i) mod NUM_ENTRIES, combinationally.
REQ-021 On accepted dispatch, tail SHALL advance by popcount(disp_valid), and each allocated entry SHALL be set valid=1, done=0, with its areg stored.
REQ-022 A completion on a valid entry SHALL set done=1 and store data at the clock edge.
REQ-023 A completion on an invalid entry SHALL be ignored.
REQ-024 If two completion ports carry the same tag, the lowest-numbered port SHALL win.
REQ-025 ret_valid[i] SHALL be 1 iff entries head..head+i are all valid and done (in-order prefix), combinational from registered state, with no backpressure.
REQ-026 At each edge, head SHALL advance by popcount(ret_valid) and the retired entries SHALL be cleared (valid=0).
REQ-027 Minimum latency SHALL be: dispatch at edge N, completion at edge N+1, ret_valid high during cycle N+1..N+2, entry freed at edge N+2.
REQ-028 count SHALL be updated as count + dispatched - retired; full=(count==NUM_ENTRIES); empty=(count==0).
REQ-029 Simultaneous dispatch, completion and retirement SHALL all take effect in the same cycle.
REQ-030 Pointer wrap SHALL be seamless; retirement and dispatch groups spanning index NUM_ENTRIES-1 to 0 SHALL be handled.
REQ-031 flush SHALL have priority over all other events: at the edge, clear all valid/done bits, set head=tail=count=0, and ignore same-cycle dispatch and completion.
REQ-032 ret_valid SHALL still be driven combinationally during a flush cycle, and consumers SHALL gate those writes with flush.

Reset
REQ-033 While rst=0, asynchronously: head=tail=count=0, all valid/done=0.
REQ-034 At reset, outputs SHALL be: ret_valid=0, full=0, empty=1, disp_ready=1, disp_tag lane i = i.
REQ-035 Assertion of rst mid-operation SHALL discard all entries immediately, with no retire output thereafter.
REQ-036 Entry data/areg storage need not be reset.

Verification
REQ-037 Dispatch 2 (areg 3,4) -> tags 0,1; complete tag 1 then tag 0 next cycle -> no retire until both done, then ret_valid=2'b11 with areg 3,4 in one cycle.
REQ-038 Fill with 32 two-lane dispatches -> full=1, disp_ready=0, count=64; a 33rd dispatch is ignored and tail is unchanged.
REQ-039 head=tail=62, dispatch 2, complete both -> retire tags 62,63; the next dispatch gets tags 0,1 (wrap).
REQ-040 Both completion ports carry tag 5 with data 0xA and 0xB -> entry 5 data = 0xA.
REQ-041 count=10 with flush, dispatch and completion asserted together -> next cycle count=0, empty=1, disp_tag lane 0 = 0.
REQ-042 rst asserted between clock edges with count=6 -> outputs take reset values before the next edge.
